encoder: RTL and testbench

- Registered 8-to-3 priority encoder.
- Samples an 8-bit one-hot (or multi-hot) input vector and outputs the index of the highest set bit, plus valid and multi-hot flags.
- Used wherever a request/flag vector must be reduced to a binary index, e.g. interrupt or arbitration front-ends.
- One-cycle registered latency, synchronous active-high reset.

---
 rtl/encoder_if.sv | 34 +++
 rtl/encoder.sv | 71 +++++++
 tb/tb_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/encoder_if.sv
// ---------------------------------------------------------------------------
// encoder_if
// Bundles the request vector and the encoded result of the priority encoder.
//
//   DATA   master -> slave   DATA_W  request vector, bit i set = index i requested
//   CODE   slave -> master   CODE_W  registered index of the highest set bit
//   valid  slave -> master   1       registered, sampled DATA was non-zero
//   multi  slave -> master   1       registered, sampled DATA had >= 2 bits set
//
// The master is the request source; the slave is the encoder itself.
// ---------------------------------------------------------------------------
interface encoder_if #(
   parameter int DATA_W = 8,
   parameter int CODE_W = 3
);
   logic [DATA_W-1:0] DATA;
   logic [CODE_W-1:0] CODE;
   logic              valid;
   logic              multi;

   modport master (
      output DATA,
      input  CODE,
      input  valid,
      input  multi
   );

   modport slave (
      input  DATA,
      output CODE,
      output valid,
      output multi
   );
endinterface : encoder_if

// File: rtl/encoder.sv
// ---------------------------------------------------------------------------
// encoder
// Registered DATA_W-to-CODE_W priority encoder. Each rising clk edge samples
// the request vector and registers the index of its highest set bit together
// with "any bit set" (valid) and "two or more bits set" (multi).
// Latency is exactly one clock; no combinational path from DATA to outputs.
//
//   clk   input   1   system clock, all state updates on the rising edge
//   rst   input   1   synchronous active-high reset, overrides DATA
//   bus   slave modport of encoder_if (DATA in; CODE, valid, multi out)
//
// CODE is 0 both for DATA=0 and DATA=1; consumers must qualify it with valid.
// ---------------------------------------------------------------------------
module encoder #(
   parameter int DATA_W = 8,
   parameter int CODE_W = 3
) (
   input  logic      clk,
   input  logic      rst,
   encoder_if.slave  bus
);

   // Reject illegal width pairings at elaboration time.
   if (DATA_W < 2 || (DATA_W & (DATA_W - 1)) != 0 || CODE_W != $clog2(DATA_W)) begin : g_bad_params
      $error("encoder: DATA_W must be a power of two >= 2 and CODE_W = log2(DATA_W)");
   end

   logic [CODE_W-1:0] code_d, code_q;
   logic              valid_d, valid_q;
   logic              multi_d, multi_q;

   // Priority scan from LSB to MSB: a later (higher) hit overwrites an earlier
   // one, so the surviving index is the most significant set bit. A hit seen
   // while another bit is already recorded means at least two bits are set,
   // which is the popcount > 1 condition without building a full adder tree.
   always_comb begin
      // NOTE: every output of this block gets a default before the loop, so no
      // path leaves a value unassigned and no latch is inferred.
      code_d  = '0;
      valid_d = 1'b0;
      multi_d = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (bus.DATA[i]) begin
            if (valid_d) begin
               multi_d = 1'b1;
            end
            valid_d = 1'b1;
            code_d  = CODE_W'(i);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q  <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         code_q  <= code_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign bus.CODE  = code_q;
   assign bus.valid = valid_q;
   assign bus.multi = multi_q;

endmodule : encoder

// File: tb/tb_encoder.sv
// ---------------------------------------------------------------------------
// tb_encoder
// Self-checking bench for the encoder. A behavioural model (MSB-down search
// and $countones) predicts the outputs for every clock edge and a compare
// process checks them 1 time unit after each rising edge. Directed steps
// with hand-computed literals pin the model, then randomized traffic follows.
// Inputs change on the falling edge, except in the hold tests which move DATA
// between edges on purpose.
// ---------------------------------------------------------------------------
module tb_encoder;

   localparam int DATA_W = 8;
   localparam int CODE_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   // Model prediction for the most recent rising edge.
   int exp_code  = 0;
   int exp_valid = 0;
   int exp_multi = 0;

   encoder_if #(.DATA_W(DATA_W), .CODE_W(CODE_W)) bus ();

   encoder #(.DATA_W(DATA_W), .CODE_W(CODE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: reset clears everything; otherwise the highest set index,
   // any-bit-set and more-than-one-bit-set of the sampled vector.
   task automatic model(input logic r, input logic [DATA_W-1:0] d,
                        output int code, output int valid, output int multi);
      code  = 0;
      valid = 0;
      multi = 0;
      if (!r) begin
         for (int i = DATA_W - 1; i >= 0; i--) begin
            if (d[i]) begin
               code = i;
               break;
            end
         end
         valid = (d != '0) ? 1 : 0;
         multi = ($countones(d) > 1) ? 1 : 0;
      end
   endtask

   // Compare process: predict from the values present at the edge, check
   // the registered outputs shortly after it.
   always @(posedge clk) begin
      int c, v, m;
      model(rst, bus.DATA, c, v, m);
      exp_code  = c;
      exp_valid = v;
      exp_multi = m;
      #1;
      check("model code",  int'(bus.CODE),  exp_code);
      check("model valid", int'(bus.valid), exp_valid);
      check("model multi", int'(bus.multi), exp_multi);
   end

   // Drive one cycle on the falling edge and check literal expectations
   // after the following rising edge.
   task automatic step(input logic r, input logic [DATA_W-1:0] d,
                       input int ec, input int ev, input int em, input string tag);
      @(negedge clk);
      rst      = r;
      bus.DATA = d;
      @(posedge clk);
      #2;
      check({tag, " code"},  int'(bus.CODE),  ec);
      check({tag, " valid"}, int'(bus.valid), ev);
      check({tag, " multi"}, int'(bus.multi), em);
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      bus.DATA = 8'hFF;

      // Reset held two cycles with all requests active.
      step(1'b1, 8'hFF, 0, 0, 0, "reset0");
      step(1'b1, 8'hFF, 0, 0, 0, "reset1");

      // One-hot walk.
      step(1'b0, 8'b1000_0000, 7, 1, 0, "onehot7");
      step(1'b0, 8'b0100_0000, 6, 1, 0, "onehot6");
      step(1'b0, 8'b0000_0001, 0, 1, 0, "onehot0");

      // Multi-hot priority.
      step(1'b0, 8'b0110_0000, 6, 1, 1, "multi60");
      step(1'b0, 8'hFF,        7, 1, 1, "multiFF");
      step(1'b0, 8'b0000_0011, 1, 1, 1, "multi03");

      // Zero versus lowest bit.
      step(1'b0, 8'h00, 0, 0, 0, "zero");
      step(1'b0, 8'h01, 0, 1, 0, "bit0");

      // Hold: DATA moves between edges, outputs must not follow until the edge.
      step(1'b0, 8'b0100_0000, 6, 1, 0, "hold_pre");
      #1;
      bus.DATA = 8'b0000_0011;
      #3;
      check("hold mid code",  int'(bus.CODE),  6);
      check("hold mid multi", int'(bus.multi), 0);
      @(posedge clk);
      #2;
      check("hold post code",  int'(bus.CODE),  1);
      check("hold post multi", int'(bus.multi), 1);
      #2;
      bus.DATA = 8'h00;
      #2;
      check("hold zero mid valid", int'(bus.valid), 1);
      @(posedge clk);
      #2;
      check("hold zero post valid", int'(bus.valid), 0);

      // Reset in the middle of a stream.
      step(1'b0, 8'b1000_0000, 7, 1, 0, "stream0");
      step(1'b1, 8'b1000_0000, 0, 0, 0, "stream_rst");
      step(1'b0, 8'b1000_0000, 7, 1, 0, "stream_resume");

      // Randomized traffic: mix of zero, one-hot, sparse and dense vectors.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0: d = '0;
            1: d = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
            2: d = DATA_W'($urandom) & DATA_W'($urandom);
            default: d = DATA_W'($urandom);
         endcase
         bus.DATA = d;
         rst      = ($urandom_range(0, 19) == 0);
      end

      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_encoder
